// File: rtl/skid_fifo_buffer.sv
// Elastic valid/ready skid buffer over a DEPTH-entry circular store; ready depends only on registered state.
// Define SKID_FIFO_BYPASS_EN to let beats fall straight through while the store is empty.
module skid_fifo_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]    mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             empty, full, push, pop;
    logic [DEPTH-1:0] wr_en;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign o_ready = !i_reset && !full;
    assign o_count = count_reg;

`ifdef SKID_FIFO_BYPASS_EN
    logic pass_through;

    // An empty store exposes the upstream beat directly; a beat taken in the
    // same cycle never touches the store.
    always_comb begin
        pass_through = empty && i_valid && i_ready;
        o_valid      = !i_reset && (empty ? i_valid : 1'b1);
        o_data       = (empty && !i_reset) ? i_data : mem_reg[rd_ptr_reg];
        push         = i_valid && o_ready && !pass_through;
        pop          = !empty && o_valid && i_ready;
    end
`else
    always_comb begin
        o_valid = !i_reset && !empty;
        o_data  = mem_reg[rd_ptr_reg];
        push    = i_valid && o_ready;
        pop     = o_valid && i_ready;
    end
`endif

    // Pointer wrap uses an explicit compare so non-power-of-2 depths work.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push)
                wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && !i_flush && (wr_ptr_reg == PW'(gi));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wr_en[i])
                    mem_reg[i] <= i_data;
        end
    end

endmodule

// File: tb/tb_skid_fifo_buffer.sv
// Bench for skid_fifo_buffer: DEPTH=4 and DEPTH=3 instances share stimulus and are
// checked every cycle against queue-based reference models.
module tb_skid_fifo_buffer;

    logic        clk = 1'b0;
    logic        in_rst, in_flush, in_v, in_r;
    logic [31:0] in_d;

    logic        ready4, valid4, ready3, valid3;
    logic [31:0] data4, data3;
    logic [2:0]  count4;
    logic [1:0]  count3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q4[$];
    logic [31:0] q3[$];

    always #5 clk = ~clk;

    skid_fifo_buffer #(.DW(32), .DEPTH(4)) dut4 (
        .i_clk(clk), .i_reset(in_rst), .i_flush(in_flush), .i_valid(in_v),
        .o_ready(ready4), .i_data(in_d), .o_valid(valid4), .i_ready(in_r),
        .o_data(data4), .o_count(count4)
    );

    skid_fifo_buffer #(.DW(32), .DEPTH(3)) dut3 (
        .i_clk(clk), .i_reset(in_rst), .i_flush(in_flush), .i_valid(in_v),
        .o_ready(ready3), .i_data(in_d), .o_valid(valid3), .i_ready(in_r),
        .o_data(data3), .o_count(count3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs of a buffer of depth D holding sz beats with head at the front.
    task automatic judge(input string n, input int D, input int sz, input logic [31:0] head,
                         input logic ov, input logic orr, input logic [31:0] od, input int oc,
                         output bit push, output bit pop);
        logic        ev, er;
        logic [31:0] ed;
        bit          thru;
        er = (sz != D);
`ifdef SKID_FIFO_BYPASS_EN
        ev   = (sz == 0) ? in_v : 1'b1;
        ed   = (sz == 0) ? in_d : head;
        thru = (sz == 0) && in_v && in_r;
`else
        ev   = (sz != 0);
        ed   = head;
        thru = 1'b0;
`endif
        chk({n, ".valid"}, 32'(ov), 32'(ev));
        chk({n, ".ready"}, 32'(orr), 32'(er));
        chk({n, ".count"}, 32'(oc), 32'(sz));
        if (ev)
            chk({n, ".data"}, od, ed);
        pop  = ev && in_r && !thru;
        push = in_v && er && !thru;
    endtask

    // One clock: drive just after the falling edge, check, model the rising edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        bit p, pp;
        in_v = v; in_d = d; in_r = r; in_flush = f;
        #1;
        judge("d4", 4, q4.size(), (q4.size() != 0) ? q4[0] : 32'h0, valid4, ready4, data4,
              int'(count4), p, pp);
        $display("d4 v=%0d d=%0h r=%0d f=%0d | ov=%0d od=%0h or=%0d cnt=%0d",
                 v, d, r, f, valid4, data4, ready4, count4);
        if (f) q4.delete();
        else begin
            if (pp) void'(q4.pop_front());
            if (p) q4.push_back(d);
        end
        judge("d3", 3, q3.size(), (q3.size() != 0) ? q3[0] : 32'h0, valid3, ready3, data3,
              int'(count3), p, pp);
        if (f) q3.delete();
        else begin
            if (pp) void'(q3.pop_front());
            if (p) q3.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        in_rst = 1'b1; in_flush = 1'b0; in_v = 1'b0; in_r = 1'b0; in_d = 32'h0;
        #1;
        chk("rst.valid4", 32'(valid4), 32'h0);
        chk("rst.ready4", 32'(ready4), 32'h0);
        chk("rst.count4", 32'(count4), 32'h0);
        chk("rst.data4", data4, 32'h0);
        chk("rst.valid3", 32'(valid3), 32'h0);
        chk("rst.ready3", 32'(ready3), 32'h0);
        @(negedge clk);
        in_rst = 1'b0;

        // Streaming with the consumer always ready.
        for (int i = 1; i <= 16; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill to full, hold 0xE until accepted, then drain.
        for (int i = 10; i <= 13; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hE, 1'b0, 1'b0);
        cycle(1'b1, 32'hE, 1'b0, 1'b0);
        cycle(1'b1, 32'hE, 1'b1, 1'b0);
        cycle(1'b1, 32'hE, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous push and pop with two entries held.
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a concurrent push.
        for (int i = 1; i <= 3; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h99, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries stored.
        cycle(1'b1, 32'h7, 1'b0, 1'b0);
        cycle(1'b1, 32'h8, 1'b0, 1'b0);
        in_v = 1'b0; in_r = 1'b1;
        #2 in_rst = 1'b1;
        #1;
        chk("arst.valid4", 32'(valid4), 32'h0);
        chk("arst.ready4", 32'(ready4), 32'h0);
        chk("arst.count4", 32'(count4), 32'h0);
        chk("arst.valid3", 32'(valid3), 32'h0);
        chk("arst.count3", 32'(count3), 32'h0);
        q4.delete();
        q3.delete();
        @(negedge clk);
        in_rst = 1'b0;
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h42, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic exercising wrap-around and stalls.
        for (int i = 0; i < 1000; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/skid_fifo_buffer.md
# skid_fifo_buffer

Parametrised valid/ready skid buffer with a circular store of DEPTH entries. It breaks the combinational ready path between pipeline stages and absorbs back-pressure without dropping or duplicating beats. It sits between the memory/load-store stage and write-back, and can also be used on any other stage boundary that needs elastic buffering. An optional fall-through bypass gives zero-latency pass-through when the store is empty.

## Interface
- DW, 32, data width in bits
- DEPTH, 2, number of storage entries; legal range is ≥2 (non-power-of-2 allowed)
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not to be overridden)

Ports:
- i_clk  input  1  clock, rising edge
- i_reset  input  1  reset, asynchronous, active-high
- i_flush  input  1  synchronous discard of all stored beats
- i_valid  input  1  upstream beat valid
- o_ready  output  1  buffer can accept a beat
- i_data  input  DW  upstream data
- o_valid  output  1  downstream beat valid
- i_ready  input  1  downstream accepts the beat
- o_data  output  DW  downstream data
- o_count  output  CW  number of stored entries, 0..DEPTH

## Operation
- State: storage array mem[DEPTH], write pointer wr_ptr, read pointer rd_ptr, and count.
  - Pointers wrap from DEPTH-1 to 0; the wrap is an explicit compare, not a power-of-2 mask.
- Push = i_valid && o_ready.
  - Writes i_data to mem[wr_ptr] and advances wr_ptr.
- Pop = o_valid && i_ready.
  - Advances rd_ptr.
- o_ready = !i_reset && (count != DEPTH).
  - o_ready is a function of registered state only; there is no combinational path from i_ready to o_ready.
  - When full, o_ready = 0 even if a pop happens in the same cycle.
- Push and pop in the same cycle (count in 1..DEPTH-1): both pointers advance and count is unchanged.
- Count updates:
  - Push only: count+1.
  - Pop only: count-1.
  - count never exceeds DEPTH and never goes below 0.
- Output stability: while o_valid && !i_ready, o_data and o_valid stay unchanged until the beat is accepted.
- Flush (i_flush=1):
  - Next cycle, count = 0 and wr_ptr = rd_ptr = 0.
  - Any push or pop in the flush cycle is discarded and does not change state.
  - o_valid may be high during the flush cycle. A downstream handshake in that cycle is still consumed by the consumer, but the beat is lost from the buffer's point of view.
- Asynchronous reset:
  - count, pointers and all mem entries go to 0.
  - While i_reset is high, o_valid = 0 and o_ready = 0.
  - Reset mid-operation discards all stored beats immediately.

## Timing
- Reset values: o_valid 0, o_ready 0 while reset is held, then 1 on the first cycle after release; o_data 0, o_count 0.
- Latency without bypass: a beat pushed in cycle N appears on o_valid/o_data in cycle N+1 at the earliest.
- Throughput: 1 beat/cycle sustained whenever i_ready = 1 and the buffer is not full.
- Full-to-not-full: after a pop from a full buffer, o_ready rises in the next cycle (one bubble on the input side).
- o_count is registered and reflects the state after the previous edge.

## Configuration
- Macro: SKID_FIFO_BYPASS_EN.
- Defined — fall-through bypass:
  - When count == 0: o_valid = i_valid and o_data = i_data, combinationally.
  - If i_ready is also high, the beat passes straight through with zero latency; no write occurs and count stays 0.
  - If i_ready is low, the beat is pushed normally. The stored value equals the value presented, so output stability holds.
  - Flush and reset override the bypass: o_valid = 0 while i_reset is high. In the flush cycle, bypass behaves as a normal pass-through and the beat is not stored.
- Undefined:
  - o_valid = (count != 0) and o_data = mem[rd_ptr].
  - Minimum latency is 1 cycle and all outputs are register-driven.

## Test plan
- Streaming: DEPTH=2, i_ready tied 1, push 0x1..0x10 back-to-back.
  - Required: output order 0x1..0x10, no gaps after the first beat, o_count ≤ 1.
  - With SKID_FIFO_BYPASS_EN: output in the same cycle as input, o_count = 0 throughout.
- Fill to full: DEPTH=4, i_ready=0, push 0xA,0xB,0xC,0xD,0xE.
  - Required: o_ready drops after the 4th push, 0xE is not accepted, o_count = 4.
  - Then i_ready=1: output 0xA,0xB,0xC,0xD, then 0xE after o_ready reasserts.
- Wrap-around: DEPTH=3, random i_valid/i_ready for 1000 beats against a reference queue.
  - Required: no loss or duplication, o_data stable while stalled, o_count matches the model every cycle.
- Simultaneous push and pop: DEPTH=4 holding 2 entries, push 0x55 with i_ready=1 for 1 cycle.
  - Required: o_count stays 2, head advances, 0x55 appears 2 pops later.
- Flush: 3 entries stored, i_flush=1 together with i_valid=1 (data 0x99).
  - Required: next cycle o_count = 0 and o_valid = 0 (non-bypass); 0x99 is never output.
- Reset mid-stream: assert i_reset asynchronously between edges with 2 entries stored.
  - Required: o_valid and o_ready drop immediately, o_count = 0.
  - After release: o_ready = 1 and no stale beat is output.
